bp_cfg_sequencer: RTL and testbench
===================================

# bp_cfg_sequencer

Boot-time configuration master that drives the per-core configuration link (`cfg_core`/`cfg_addr`/`cfg_data`) after reset. On `start_i` it:
- freezes every core,
- programs each core's reset PC and core ID,
- streams the CCE microcode image from an external ROM into each core's CCE,
- switches each CCE to normal mode,
- unfreezes all cores.

It sits between the top-level boot logic and the cfg network fan-out, and serializes all boot-time cfg traffic onto one valid/ready link.

## Interface
Parameters:
- `num_core_p`, 1, number of cores to configure (≥1)
- `cfg_core_width_p`, 8, width of the core select field
- `cfg_addr_width_p`, 16, width of the cfg register address
- `cfg_data_width_p`, 64, width of the cfg write data
- `cce_pc_width_p`, 8, microcode address width; image holds 2^`cce_pc_width_p` words
- `cce_instr_width_p`, 48, microcode word width (≤ `cfg_data_width_p`)
- `reset_pc_p`, 64'h8000_0000, reset PC written to every core

Ports:
- `clk_i`  in  1  sole clock
- `reset_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  begin boot sequence; sampled only in IDLE or DONE
- `busy_o`  out  1  sequence in progress
- `done_o`  out  1  level; high in DONE until the next accepted start or reset
- `cfg_v_o`  out  1  cfg write valid
- `cfg_ready_i`  in  1  downstream accepts the write
- `cfg_core_o`  out  `cfg_core_width_p`  target core
- `cfg_addr_o`  out  `cfg_addr_width_p`  register address
- `cfg_data_o`  out  `cfg_data_width_p`  write data
- `rom_addr_o`  out  `cce_pc_width_p`  microcode ROM address
- `rom_data_i`  in  `cce_instr_width_p`  ROM data; valid one cycle after `rom_addr_o`

## Operation
Register map, all writes:
- FREEZE 16'h0001: data 1 = freeze, 0 = unfreeze
- RESET_PC 16'h0002
- CORE_ID 16'h0003: data = core index
- CCE_MODE 16'h0004: data 1 = normal
- UCODE 16'h8000 + pc: data = zero-extended `rom_data_i`

FSM states:
- IDLE
  - `start_i` → FRZ; clear core counter and pc counter.
- FRZ
  - Write FREEZE=1 to the core in the core counter.
  - On handshake: increment the core counter. After the last core, wrap the counter to 0 → PC.
- PC
  - Write RESET_PC=`reset_pc_p`.
  - On handshake → ID.
- ID
  - Write CORE_ID = core counter.
  - On handshake → FETCH; clear the pc counter.
- FETCH
  - Drive `rom_addr_o` = pc counter for one cycle. `cfg_v_o`=0.
  - Next cycle → UCODE, capturing `rom_data_i` into a data register.
- UCODE
  - Write UCODE+pc with the captured data.
  - On handshake: if pc is the maximum value → MODE; otherwise increment pc → FETCH.
- MODE
  - Write CCE_MODE=1.
  - On handshake: if this is the last core → UNFRZ with the core counter reset to 0; otherwise increment the core counter → PC.
- UNFRZ
  - Write FREEZE=0, one per core, in ascending core order.
  - After the last core → DONE.
- DONE
  - `done_o`=1.
  - `start_i` → FRZ, repeating the full sequence.

General rules:
- A handshake is `cfg_v_o` & `cfg_ready_i` in the same cycle.
- `cfg_v_o` is asserted only in FRZ, PC, ID, UCODE, MODE and UNFRZ.
- Once `cfg_v_o` rises, `cfg_core_o`/`cfg_addr_o`/`cfg_data_o` hold stable until the handshake. `cfg_v_o` never drops without a handshake.
- `rom_addr_o` equals the pc counter in every state, so it holds steady while UCODE waits for ready.
- `busy_o` is high in every state except IDLE and DONE. `start_i` is ignored while busy.
- Counter widths:
  - core counter is `$clog2(num_core_p)` bits, minimum 1;
  - pc counter is `cce_pc_width_p` bits, and the last-word test is pc == all-ones (no wrap past it).
- Core 0 always receives the complete ucode image before core 1 receives its RESET_PC.
- Total writes = 2·N + N·(3 + 2^`cce_pc_width_p`).

## Timing
- Reset values:
  - state IDLE; `busy_o`=0, `done_o`=0, `cfg_v_o`=0;
  - `cfg_core_o`=0, `cfg_addr_o`=0, `cfg_data_o`=0, `rom_addr_o`=0.
- `reset_i` mid-sequence returns to IDLE the next cycle and drops `cfg_v_o` without a handshake. The downstream treats this as an abandoned write.
- `start_i` at edge t → `cfg_v_o`=1 with FREEZE at t+1.
- With `cfg_ready_i` tied high:
  - each non-ucode write takes 1 cycle;
  - each ucode word takes 2 cycles (FETCH + UCODE).
- Backpressure stretches only the current write. No write is skipped or duplicated.
- `done_o` rises the cycle after the final UNFRZ handshake.

## Test plan
- N=1, pc_width=2, ready=1, ROM word[i]=i+1. Start at cycle 0 → exactly 9 handshakes, in order:
  - FREEZE=1;
  - RESET_PC=0x8000_0000;
  - CORE_ID=0;
  - UCODE 0x8000..0x8003 with data 1..4;
  - CCE_MODE=1;
  - FREEZE=0.

  `done_o` rises at cycle 14.
- N=2, pc_width=1: writes appear in order FRZ c0, FRZ c1, then c0 {PC, ID, U0, U1, MODE}, c1 {PC, ID=1, U0, U1, MODE}, then UNFRZ c0, UNFRZ c1.
- Random `cfg_ready_i` (~30% high) → the same write list as under ready=1, and payload is stable across every stall.
- Reset asserted during the UCODE state with `cfg_v_o` high → next cycle `cfg_v_o`=0, `busy_o`=0. A new `start_i` reruns the full list from FREEZE.
- Extra `start_i` pulses while busy → no effect on the sequence. `start_i` in DONE → `done_o`=0 next cycle and the list repeats identically.

Source files
------------

// File: rtl/bp_cfg_sequencer.sv
// ============================================================================
// Module   : bp_cfg_sequencer
// Purpose  : Boot-time cfg master that freezes, programs, loads CCE microcode
//            into and unfreezes every core over one valid/ready cfg link.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_cfg_sequencer #(
  parameter int          num_core_p        = 1,
  parameter int          cfg_core_width_p  = 8,
  parameter int          cfg_addr_width_p  = 16,
  parameter int          cfg_data_width_p  = 64,
  parameter int          cce_pc_width_p    = 8,
  parameter int          cce_instr_width_p = 48,
  parameter logic [63:0] reset_pc_p        = 64'h8000_0000
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         cfg_v_o,
  input  logic                         cfg_ready_i,
  output logic [cfg_core_width_p-1:0]  cfg_core_o,
  output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
  output logic [cfg_data_width_p-1:0]  cfg_data_o,
  output logic [cce_pc_width_p-1:0]    rom_addr_o,
  input  logic [cce_instr_width_p-1:0] rom_data_i
);

  localparam int c_CORE_W = (num_core_p > 1) ? $clog2(num_core_p) : 1;
  localparam logic [c_CORE_W-1:0] c_LAST_CORE = c_CORE_W'(num_core_p - 1);

  localparam logic [cfg_addr_width_p-1:0] c_ADDR_FREEZE   = cfg_addr_width_p'(16'h0001);
  localparam logic [cfg_addr_width_p-1:0] c_ADDR_RESET_PC = cfg_addr_width_p'(16'h0002);
  localparam logic [cfg_addr_width_p-1:0] c_ADDR_CORE_ID  = cfg_addr_width_p'(16'h0003);
  localparam logic [cfg_addr_width_p-1:0] c_ADDR_CCE_MODE = cfg_addr_width_p'(16'h0004);
  localparam logic [cfg_addr_width_p-1:0] c_ADDR_UCODE    = cfg_addr_width_p'(16'h8000);

  localparam logic [3:0] c_ST_IDLE  = 4'd0;
  localparam logic [3:0] c_ST_FRZ   = 4'd1;
  localparam logic [3:0] c_ST_PC    = 4'd2;
  localparam logic [3:0] c_ST_ID    = 4'd3;
  localparam logic [3:0] c_ST_FETCH = 4'd4;
  localparam logic [3:0] c_ST_UCODE = 4'd5;
  localparam logic [3:0] c_ST_MODE  = 4'd6;
  localparam logic [3:0] c_ST_UNFRZ = 4'd7;
  localparam logic [3:0] c_ST_DONE  = 4'd8;

  logic [3:0]                   r_state;
  logic [c_CORE_W-1:0]          r_core;
  logic [cce_pc_width_p-1:0]    r_pc;
  logic [cce_instr_width_p-1:0] r_ucode;
  logic                         w_hs;
  logic                         w_last_core;

  assign w_hs        = cfg_v_o & cfg_ready_i;
  assign w_last_core = (r_core == c_LAST_CORE);
  assign rom_addr_o  = r_pc;
  assign busy_o      = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
  assign done_o      = (r_state == c_ST_DONE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= c_ST_IDLE;
      r_core  <= '0;
      r_pc    <= '0;
      r_ucode <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (start_i) begin
            r_state <= c_ST_FRZ;
            r_core  <= '0;
            r_pc    <= '0;
          end
        end
        c_ST_FRZ: begin
          if (w_hs) begin
            if (w_last_core) begin
              r_core  <= '0;
              r_state <= c_ST_PC;
            end else begin
              r_core <= r_core + c_CORE_W'(1);
            end
          end
        end
        c_ST_PC: begin
          if (w_hs) r_state <= c_ST_ID;
        end
        c_ST_ID: begin
          if (w_hs) begin
            r_state <= c_ST_FETCH;
            r_pc    <= '0;
          end
        end
        c_ST_FETCH: begin
          r_ucode <= rom_data_i;
          r_state <= c_ST_UCODE;
        end
        c_ST_UCODE: begin
          // Last-word test is all-ones so the pc never wraps back to zero.
          if (w_hs) begin
            if (&r_pc) begin
              r_state <= c_ST_MODE;
            end else begin
              r_pc    <= r_pc + cce_pc_width_p'(1);
              r_state <= c_ST_FETCH;
            end
          end
        end
        c_ST_MODE: begin
          if (w_hs) begin
            if (w_last_core) begin
              r_core  <= '0;
              r_state <= c_ST_UNFRZ;
            end else begin
              r_core  <= r_core + c_CORE_W'(1);
              r_state <= c_ST_PC;
            end
          end
        end
        c_ST_UNFRZ: begin
          if (w_hs) begin
            if (w_last_core) begin
              r_core  <= '0;
              r_state <= c_ST_DONE;
            end else begin
              r_core <= r_core + c_CORE_W'(1);
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Payload is a pure decode of held state, so it cannot move during a stall.
  always_comb begin
    cfg_v_o    = 1'b0;
    cfg_core_o = '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    case (r_state)
      c_ST_FRZ: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = cfg_core_width_p'(r_core);
        cfg_addr_o = c_ADDR_FREEZE;
        cfg_data_o = cfg_data_width_p'(1);
      end
      c_ST_PC: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = cfg_core_width_p'(r_core);
        cfg_addr_o = c_ADDR_RESET_PC;
        cfg_data_o = cfg_data_width_p'(reset_pc_p);
      end
      c_ST_ID: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = cfg_core_width_p'(r_core);
        cfg_addr_o = c_ADDR_CORE_ID;
        cfg_data_o = cfg_data_width_p'(r_core);
      end
      c_ST_UCODE: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = cfg_core_width_p'(r_core);
        cfg_addr_o = c_ADDR_UCODE + cfg_addr_width_p'(r_pc);
        cfg_data_o = cfg_data_width_p'(r_ucode);
      end
      c_ST_MODE: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = cfg_core_width_p'(r_core);
        cfg_addr_o = c_ADDR_CCE_MODE;
        cfg_data_o = cfg_data_width_p'(1);
      end
      c_ST_UNFRZ: begin
        cfg_v_o    = 1'b1;
        cfg_core_o = cfg_core_width_p'(r_core);
        cfg_addr_o = c_ADDR_FREEZE;
        cfg_data_o = '0;
      end
      default: begin
        cfg_v_o = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_cfg_sequencer.sv
// ============================================================================
// Module   : tb_bp_cfg_sequencer
// Purpose  : Scoreboard bench for bp_cfg_sequencer; two instances run side by
//            side (1 core / 4-word image, 2 cores / 2-word image).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bp_cfg_sequencer;

  typedef struct packed {
    logic [7:0]  core;
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic             ready;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0]       v;
  logic [1:0][7:0]  core;
  logic [1:0][15:0] addr;
  logic [1:0][63:0] data;
  logic [1:0][47:0] rom_data;
  logic [1:0]       rom_addr0;
  logic [0:0]       rom_addr1;

  int checks = 0;
  int errors = 0;

  wr_t q0[$];
  wr_t q1[$];

  logic [1:0] prev_v;
  logic [1:0] prev_hs;
  wr_t        prev_w [2];
  logic       prev_rst;
  wr_t        mon_got;
  wr_t        mon_exp;
  logic       mon_hs;
  logic       mon_empty;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data[0] = 48'(rom_addr0) + 48'd1;
  assign rom_data[1] = 48'hA5_0000 + 48'(rom_addr1);

  bp_cfg_sequencer #(.num_core_p(1), .cce_pc_width_p(2)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .busy_o(busy[0]), .done_o(done[0]),
    .cfg_v_o(v[0]), .cfg_ready_i(ready), .cfg_core_o(core[0]), .cfg_addr_o(addr[0]),
    .cfg_data_o(data[0]), .rom_addr_o(rom_addr0), .rom_data_i(rom_data[0])
  );

  bp_cfg_sequencer #(.num_core_p(2), .cce_pc_width_p(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .busy_o(busy[1]), .done_o(done[1]),
    .cfg_v_o(v[1]), .cfg_ready_i(ready), .cfg_core_o(core[1]), .cfg_addr_o(addr[1]),
    .cfg_data_o(data[1]), .rom_addr_o(rom_addr1), .rom_data_i(rom_data[1])
  );

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      mon_got.core = core[s];
      mon_got.addr = addr[s];
      mon_got.data = data[s];
      mon_hs = v[s] & ready;
      if (!reset) begin
        if (prev_v[s] && !prev_hs[s] && !prev_rst) begin
          checks++;
          if (!v[s] || mon_got !== prev_w[s]) begin
            errors++;
            $display("FAIL stall_hold dut%0d: got v=%0b %h, required v=1 %h", s, v[s], mon_got, prev_w[s]);
          end
        end
        if (mon_hs) begin
          checks++;
          mon_empty = (s == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (mon_empty) begin
            errors++;
            $display("FAIL extra_write dut%0d: got %h, required no write", s, mon_got);
          end else begin
            mon_exp = (s == 0) ? q0.pop_front() : q1.pop_front();
            if (mon_got !== mon_exp) begin
              errors++;
              $display("FAIL write dut%0d: got %h, required %h", s, mon_got, mon_exp);
            end
          end
        end
      end
      prev_v[s]  = v[s];
      prev_hs[s] = mon_hs;
      prev_w[s]  = mon_got;
    end
    prev_rst = reset;
  end

  task automatic push_wr(input int sel, input int c, input logic [15:0] a, input logic [63:0] d);
    wr_t w;
    w.core = 8'(c);
    w.addr = a;
    w.data = d;
    if (sel == 0) q0.push_back(w);
    else          q1.push_back(w);
  endtask

  task automatic push_list(input int sel);
    int n     = (sel == 0) ? 1 : 2;
    int words = (sel == 0) ? 4 : 2;
    logic [63:0] rv;
    for (int c = 0; c < n; c++) push_wr(sel, c, 16'h0001, 64'd1);
    for (int c = 0; c < n; c++) begin
      push_wr(sel, c, 16'h0002, 64'h8000_0000);
      push_wr(sel, c, 16'h0003, 64'(c));
      for (int w = 0; w < words; w++) begin
        rv = (sel == 0) ? 64'(w + 1) : (64'hA5_0000 + 64'(w));
        push_wr(sel, c, 16'h8000 + 16'(w), rv);
      end
      push_wr(sel, c, 16'h0004, 64'd1);
    end
    for (int c = 0; c < n; c++) push_wr(sel, c, 16'h0001, 64'd0);
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (done == 2'b11) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d/%0d pending writes, required 0/0", name, q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (v[s] !== 1'b0 || busy[s] !== 1'b0 || done[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags dut%0d: got v/busy/done=%b%b%b, required 000", s, v[s], busy[s], done[s]);
      end
      checks++;
      if (core[s] !== 8'd0 || addr[s] !== 16'd0 || data[s] !== 64'd0) begin
        errors++;
        $display("FAIL reset_payload dut%0d: got %h %h %h, required zeros", s, core[s], addr[s], data[s]);
      end
    end
    checks++;
    if (rom_addr0 !== 2'd0 || rom_addr1 !== 1'd0) begin
      errors++;
      $display("FAIL reset_rom_addr: got %0d/%0d, required 0/0", rom_addr0, rom_addr1);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_full_sequence();
    int cyc = 0;
    int d0 = -1;
    int d1 = -1;
    ready = 1'b1;
    push_list(0); push_list(1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < 200 && (d0 < 0 || d1 < 0)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (v !== 2'b11 || addr[0] !== 16'h0001 || addr[1] !== 16'h0001) begin
          errors++;
          $display("FAIL first_write: got v=%b addr=%h/%h, required v=11 addr=0001", v, addr[0], addr[1]);
        end
      end
      if (d0 < 0 && done[0]) d0 = cyc;
      if (d1 < 0 && done[1]) d1 = cyc;
    end
    checks++;
    if (d0 != 14) begin
      errors++;
      $display("FAIL done_cycle dut0: got %0d, required 14", d0);
    end
    checks++;
    if (d1 != 19) begin
      errors++;
      $display("FAIL done_cycle dut1: got %0d, required 19", d1);
    end
    check_drained("full");
  endtask

  task automatic test_backpressure();
    bit ok = 1'b0;
    push_list(0); push_list(1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 9) < 3);
      @(posedge clk); #1;
      if (done == 2'b11) begin
        ok = 1'b1;
        break;
      end
    end
    ready = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL backpressure_timeout: got done=%b, required 11", done);
    end
    check_drained("backpressure");
  endtask

  task automatic test_reset_mid_ucode();
    bit found = 1'b0;
    bit ok;
    ready = 1'b1;
    push_list(0); push_list(1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (v[0] && addr[0][15]) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_ucode: got no ucode write, required one");
    end
    ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (v !== 2'b00 || busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_abort: got v=%b busy=%b, required 00/00", v, busy);
    end
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    ready = 1'b1;
    push_list(0); push_list(1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rerun_timeout: got done=%b, required 11", done);
    end
    check_drained("rerun");
  endtask

  task automatic test_extra_start_and_restart();
    bit ok;
    ready = 1'b1;
    push_list(0); push_list(1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      start = (i == 3 || i == 5 || i == 8);
    end
    start = 1'b0;
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL extra_start_timeout: got done=%b, required 11", done);
    end
    check_drained("extra_start");
    push_list(0); push_list(1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 2'b00 || busy !== 2'b11) begin
      errors++;
      $display("FAIL restart_flags: got done=%b busy=%b, required 00/11", done, busy);
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_timeout: got done=%b, required 11", done);
    end
    check_drained("restart");
  endtask

  initial begin
    prev_v = '0; prev_hs = '0; prev_rst = 1'b1;
    prev_w[0] = '0; prev_w[1] = '0;
    test_reset();
    test_full_sequence();
    test_backpressure();
    test_reset_mid_ucode();
    test_extra_start_and_restart();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
